// File: rtl/uart_pkg.sv
// Shared types for the UART receive drain path: buffered entry layout,
// handshake FSM encodings and the default buffer depth.
package uart_pkg;

  localparam int DEFAULT_DEPTH = 16;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ACK  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO; head visible the cycle after its push edge.
// A push into a full FIFO is accepted only alongside a pop; pops while empty are ignored.
module sync_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // Full FIFO can still take a word when the head leaves in the same cycle.
    do_push  = push && ((count_q != CNT_FULL) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign count   = count_q;
  assign pop_dat = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_rx_fifo.sv
// Drains the UART receiver with a one-cycle r_rdn strobe into a FWFT buffer; entry visible one cycle after capture.
// CPU side is valid/ready; when full, bytes are dropped and the sticky overflow flag is raised.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 4
) (
  input  logic          clk16x,
  input  logic          clr,
  input  logic          r_ready,
  input  logic [7:0]    r_d_out,
  input  logic          r_parity_error,
  input  logic          r_frame_error,
  output logic          r_rdn,
  output logic [7:0]    dout,
  output logic          perr,
  output logic          ferr,
  output logic          dvalid,
  input  logic          dready,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clr
);

  state_t    state_q, state_d;
  logic      cap_q, cap_d;
  logic      rdn_q, rdn_d;
  logic      ovf_q, ovf_d;
  logic      push;
  logic      fifo_full, fifo_empty;
  logic      pop_fire;
  rx_entry_t in_ent, out_ent;

  assign in_ent = '{ferr: r_frame_error, perr: r_parity_error, data: r_d_out};

  // cap_q remembers that r_ready was seen in IDLE; the byte is taken one edge later.
  always_comb begin
    state_d = state_q;
    cap_d   = 1'b0;
    rdn_d   = 1'b1;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cap_q) begin
          push    = 1'b1;
          rdn_d   = 1'b0;
          state_d = ST_ACK;
        end else begin
          cap_d = r_ready;
        end
      end
      ST_ACK:  state_d = ST_WAIT;
      ST_WAIT: if (!r_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop_fire = dready && !fifo_empty;
    ovf_d    = ovf_q;
    if (push && fifo_full && !pop_fire) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk16x) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cap_q   <= 1'b0;
      rdn_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      rdn_q   <= rdn_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .W     ($bits(rx_entry_t)),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk16x),
    .clr      (clr),
    .push     (push),
    .push_dat (in_ent),
    .pop      (dready),
    .pop_dat  (out_ent),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count)
  );

  assign r_rdn    = rdn_q;
  assign overflow = ovf_q;
  assign dvalid   = !fifo_empty;
  assign dout     = out_ent.data;
  assign perr     = out_ent.perr;
  assign ferr     = out_ent.ferr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboarded bench for uart_rx_fifo: directed receiver bytes, CPU pops checked by a negedge monitor.
module tb_uart_rx_fifo;

  logic       clk16x = 1'b0;
  logic       clr;
  logic       r_ready;
  logic [7:0] r_d_out;
  logic       r_parity_error;
  logic       r_frame_error;
  logic       r_rdn;
  logic [7:0] dout;
  logic       perr;
  logic       ferr;
  logic       dvalid;
  logic       dready;
  logic [4:0] count;
  logic       overflow;
  logic       ovf_clr;

  int         checks   = 0;
  int         failures = 0;
  int         rdn_lows = 0;
  int         base;
  logic [9:0] exp_q[$];

  always #5 clk16x = ~clk16x;

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk16x         (clk16x),
    .clr            (clr),
    .r_ready        (r_ready),
    .r_d_out        (r_d_out),
    .r_parity_error (r_parity_error),
    .r_frame_error  (r_frame_error),
    .r_rdn          (r_rdn),
    .dout           (dout),
    .perr           (perr),
    .ferr           (ferr),
    .dvalid         (dvalid),
    .dready         (dready),
    .count          (count),
    .overflow       (overflow),
    .ovf_clr        (ovf_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  // Monitor: every accepted pop is compared with the scoreboard head.
  always @(negedge clk16x) begin
    if (!r_rdn) rdn_lows++;
    if (!clr && dvalid && dready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual=%0h expected=none", {ferr, perr, dout});
      end else begin
        chk("pop_entry", {22'd0, ferr, perr, dout}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk16x);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic pe, input logic fe,
                           input bit exp_push, input int hold);
    bit got;
    got            = 1'b0;
    r_d_out        = d;
    r_parity_error = pe;
    r_frame_error  = fe;
    r_ready        = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      tick();
      if (!r_rdn) got = 1'b1;
    end
    ovf_clr = 1'b0;
    chk("rdn_strobe", {31'd0, got}, 32'd1);
    if (exp_push) exp_q.push_back({fe, pe, d});
    tick();
    chk("rdn_release", {31'd0, r_rdn}, 32'd1);
    repeat (hold) tick();
    r_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain();
    dready = 1'b1;
    for (int k = 0; k < 40 && count != 0; k++) tick();
    dready = 1'b0;
    chk("drain_count", {27'd0, count}, 32'd0);
    chk("drain_sb_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; r_ready = 1'b0; r_d_out = 8'h00; r_parity_error = 1'b0;
    r_frame_error = 1'b0; dready = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();
    chk("rst_rdn",      {31'd0, r_rdn},    32'd1);
    chk("rst_count",    {27'd0, count},    32'd0);
    chk("rst_dvalid",   {31'd0, dvalid},   32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_head",     {22'd0, ferr, perr, dout}, 32'd0);
    clr = 1'b0;
    tick();

    // Single byte with exact strobe timing.
    base    = rdn_lows;
    r_d_out = 8'h5A;
    r_ready = 1'b1;
    tick();
    chk("sb_rdn_edge1", {31'd0, r_rdn}, 32'd1);
    tick();
    chk("sb_rdn_edge2",  {31'd0, r_rdn},  32'd0);
    chk("sb_dvalid",     {31'd0, dvalid}, 32'd1);
    chk("sb_head",       {22'd0, ferr, perr, dout}, 32'h05A);
    chk("sb_count",      {27'd0, count},  32'd1);
    exp_q.push_back(10'h05A);
    r_ready = 1'b0;
    tick();
    chk("sb_rdn_edge3", {31'd0, r_rdn}, 32'd1);
    tick();
    chk("sb_one_pulse", rdn_lows - base, 32'd1);
    dready = 1'b1;
    tick();
    dready = 1'b0;
    chk("sb_pop_count",  {27'd0, count},  32'd0);
    chk("sb_pop_dvalid", {31'd0, dvalid}, 32'd0);

    // Error tagging, order preserved.
    send_byte(8'hC3, 1'b0, 1'b1, 1'b1, 0);
    send_byte(8'h11, 1'b1, 1'b0, 1'b1, 0);
    chk("err_count", {27'd0, count}, 32'd2);
    drain();

    // Fill, then overflow on the 17th byte while ovf_clr is also asserted.
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0, 1'b1, 0);
    chk("fill_no_ovf", {31'd0, overflow}, 32'd0);
    ovf_clr = 1'b1;
    send_byte(8'h10, 1'b0, 1'b0, 1'b0, 0);
    chk("fill_count", {27'd0, count},    32'd16);
    chk("ovf_wins",   {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);
    drain();

    // Pop request while empty must do nothing.
    dready = 1'b1;
    tick();
    dready = 1'b0;
    chk("empty_pop_count",  {27'd0, count},  32'd0);
    chk("empty_pop_dvalid", {31'd0, dvalid}, 32'd0);

    // Full FIFO, capture coincides with a pop.
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b0, 1'b0, 1'b1, 0);
    chk("full_count", {27'd0, count}, 32'd16);
    r_d_out = 8'hAA;
    r_ready = 1'b1;
    tick();
    chk("aa_pre_strobe", {31'd0, r_rdn}, 32'd1);
    dready = 1'b1;
    tick();
    dready = 1'b0;
    chk("aa_strobe",   {31'd0, r_rdn},    32'd0);
    exp_q.push_back(10'h0AA);
    chk("aa_count",    {27'd0, count},    32'd16);
    chk("aa_overflow", {31'd0, overflow}, 32'd0);
    r_ready = 1'b0;
    tick();
    tick();
    drain();

    // Held r_ready: one strobe, one entry, until it falls and rises again.
    base = rdn_lows;
    send_byte(8'h77, 1'b0, 1'b0, 1'b1, 20);
    chk("held_single_strobe", rdn_lows - base, 32'd1);
    chk("held_one_entry",     {27'd0, count},  32'd1);
    send_byte(8'h78, 1'b0, 1'b0, 1'b1, 0);
    chk("held_second_strobe", rdn_lows - base, 32'd2);
    chk("held_two_entries",   {27'd0, count},  32'd2);
    drain();

    // Pointer wrap: 40 bytes with interleaved pops.
    for (int i = 0; i < 40; i++) begin
      send_byte(8'h80 + 8'(i), (i % 5) == 0, (i % 7) == 0, 1'b1, 0);
      if ((i % 3) != 0) begin
        dready = 1'b1;
        tick();
        dready = 1'b0;
      end
    end
    chk("wrap_count", {27'd0, count}, 32'd14);
    drain();

    // Reset while r_rdn is low discards buffered entries.
    send_byte(8'h33, 1'b0, 1'b0, 1'b0, 0);
    r_d_out = 8'h44;
    r_ready = 1'b1;
    tick();
    tick();
    chk("mid_ack_strobe", {31'd0, r_rdn}, 32'd0);
    chk("mid_ack_count",  {27'd0, count}, 32'd2);
    clr     = 1'b1;
    r_ready = 1'b0;
    tick();
    clr = 1'b0;
    chk("clr_rdn",      {31'd0, r_rdn},    32'd1);
    chk("clr_count",    {27'd0, count},    32'd0);
    chk("clr_dvalid",   {31'd0, dvalid},   32'd0);
    chk("clr_overflow", {31'd0, overflow}, 32'd0);
    chk("clr_head",     {22'd0, ferr, perr, dout}, 32'd0);
    tick();
    send_byte(8'h55, 1'b1, 1'b1, 1'b1, 0);
    chk("post_clr_count", {27'd0, count}, 32'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side drain stage that sits directly downstream of the UART receiver on the same clk16x domain.
- Watches the receiver's r_ready, issues a one-cycle active-low read strobe, and captures each byte together with its parity and frame error flags.
- Buffers entries in a DEPTH-entry first-word-fall-through FIFO and presents them to the CPU side via a valid/ready handshake.
- Lets the CPU poll bursts of bytes without losing characters between reads.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, at least 2.
- AW, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk16x  in  1  baud*16 clock, same clock as the UART.
- clr  in  1  reset; synchronous, active-high.
- r_ready  in  1  receiver holds a valid byte.
- r_d_out  in  8  receiver data byte.
- r_parity_error  in  1  receiver parity error for the current byte.
- r_frame_error  in  1  receiver frame error for the current byte.
- r_rdn  out  1  read strobe to the receiver, active low; registered.
- dout  out  8  head-entry data.
- perr  out  1  head-entry parity error.
- ferr  out  1  head-entry frame error.
- dvalid  out  1  FIFO non-empty.
- dready  in  1  CPU consumes the head entry when dvalid=1 and dready=1.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Single clock clk16x. Reset is synchronous and active-high on clr, sampled at the rising edge.
- Reset values: r_rdn=1, count=0, dvalid=0, overflow=0, dout/perr/ferr=0, FSM=IDLE, write and read pointers=0. Storage contents are not reset.
- A clr asserted mid-handshake forces IDLE and r_rdn=1 on the next edge and discards all buffered entries.
- FSM states are IDLE, ACK and WAIT:
  - IDLE: if r_ready=1 at edge N, then at edge N+1 capture {r_frame_error, r_parity_error, r_d_out}, attempt a push, set r_rdn<=0 and go to ACK. Otherwise stay in IDLE.
  - ACK: at the next edge set r_rdn<=1 and go to WAIT. r_rdn is therefore low for exactly one cycle.
  - WAIT: stay while r_ready=1. When r_ready=0, go to IDLE. This prevents double-reading one byte.
- Capture-to-dvalid latency: the entry is visible at dout and dvalid=1 in the cycle after the capture edge. Minimum byte-to-byte service is 4 cycles, which is well under one 16-cycle bit time.
- Push rule: the push succeeds if count<DEPTH, or if a pop occurs in the same cycle (full with simultaneous pop → push accepted, count unchanged).
- Overflow: if the push fails, the byte is dropped, overflow<=1 and the handshake still completes, so the receiver is always drained.
- overflow clear:
  - ovf_clr=1 clears overflow on the next edge.
  - If ovf_clr and a new overflow happen in the same cycle, the new overflow wins and overflow=1.
- Pop: when dvalid & dready, the read pointer advances.
- FWFT output: dout/perr/ferr always show mem[rd_ptr] when dvalid=1, and are 0 when the FIFO is empty.
- dready while empty is ignored; no pointer or count change.
- Pointers: AW bits, wrap modulo DEPTH.
- count update per cycle: count + push − pop. A simultaneous push and pop leaves count unchanged. count never exceeds DEPTH and never goes below 0.
- dvalid = (count != 0).

Decomposition:
- Shared package uart_pkg:
  - rx entry typedef {ferr, perr, data[7:0]} (10 bits).
  - FSM state enum {IDLE, ACK, WAIT}.
  - Default DEPTH constant.
- One natural sub-module: sync_fifo, a generic FWFT FIFO with push/pop/full/empty/count, parameterized by width and depth. uart_rx_fifo holds the handshake FSM and overflow logic.

Test Plan:
- Reset mid-ACK: assert clr while r_rdn=0 → next edge r_rdn=1, count=0, dvalid=0, overflow=0.
- Single byte: r_ready pulse with r_d_out=0x5A and no errors → r_rdn low for exactly one cycle two edges later; then dvalid=1, dout=0x5A, perr=0, ferr=0, count=1; after a dready pulse, count=0 and dvalid=0.
- Error tagging: byte 0xC3 with r_frame_error=1, followed by byte 0x11 with r_parity_error=1 → pops return {0xC3, ferr=1, perr=0} then {0x11, ferr=0, perr=1}, in order.
- Fill and overflow: 17 bytes 0x00..0x10 with dready=0 → count=16, overflow=1, 0x10 dropped; popping returns 0x00..0x0F. ovf_clr=1 → overflow=0.
- Full with simultaneous pop: FIFO full, new byte 0xAA captured in the same cycle as a dready pop → count stays 16, overflow=0, and 0xAA is the last entry popped.
- Held r_ready: r_ready kept high 20 cycles after the strobe → exactly one entry pushed and a single r_rdn pulse; the next byte is read only after r_ready falls and rises again. Pointer wrap is checked by 40 sequential bytes with interleaved pops, all data in order.
